// File: rtl/bit_run_monitor.sv
`default_nettype none
// ============================================================================
// Module   : bit_run_monitor
// Purpose  : Synchronises a serial bit and reports each complete run length.
// Revision : 1.0  initial release
// ============================================================================
module bit_run_monitor #(
  parameter int CNT_W       = 8,
  parameter int SYNC_STAGES = 2
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             din,
  input  logic             en,
  input  logic             clr,
  output logic             run_valid,
  output logic [CNT_W-1:0] run_len,
  output logic             run_level,
  output logic             run_sat,
  output logic [15:0]      run_cnt_total,
  output logic             ovf_flag
);

  localparam logic [CNT_W-1:0] CNT_MAX = '1;
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  typedef enum logic [0:0] {
    IDLE  = 1'b0,
    COUNT = 1'b1
  } state_t;

  state_t                 state;
  logic [SYNC_STAGES-1:0] sync_q;
  logic                   s;
  logic                   s_d;
  logic                   edge_det;
  logic [CNT_W-1:0]       counter;

  generate
    if (SYNC_STAGES == 1) begin : g_sync_single
      always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
          sync_q <= '0;
        end else begin
          sync_q <= din;
        end
      end
    end else begin : g_sync_chain
      always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
          sync_q <= '0;
        end else begin
          sync_q <= {sync_q[SYNC_STAGES-2:0], din};
        end
      end
    end
  endgenerate

  assign s        = sync_q[SYNC_STAGES-1];
  assign edge_det = en & (s != s_d);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      s_d           <= 1'b0;
      state         <= IDLE;
      counter       <= '0;
      run_valid     <= 1'b0;
      run_len       <= '0;
      run_level     <= 1'b0;
      run_sat       <= 1'b0;
      run_cnt_total <= '0;
      ovf_flag      <= 1'b0;
    end else begin
      s_d       <= s;
      run_valid <= 1'b0;

      case (state)
        IDLE: begin
          // The run in progress before the first edge has unknown start, so it is never reported.
          if (edge_det) begin
            state     <= COUNT;
            counter   <= CNT_ONE;
            run_level <= s;
          end
        end
        COUNT: begin
          if (!en) begin
            state   <= IDLE;
            counter <= '0;
          end else if (edge_det) begin
            run_valid <= 1'b1;
            run_len   <= counter;
            run_level <= s_d;
            run_sat   <= (counter == CNT_MAX);
            counter   <= CNT_ONE;
          end else if (counter != CNT_MAX) begin
            counter <= counter + CNT_ONE;
          end
        end
        default: begin
          state   <= IDLE;
          counter <= '0;
        end
      endcase

      // Statistics follow the registered report, so a clear coinciding with it wins.
      if (clr) begin
        run_cnt_total <= '0;
        ovf_flag      <= 1'b0;
      end else if (run_valid) begin
        run_cnt_total <= run_cnt_total + 16'd1;
        if (run_sat) begin
          ovf_flag <= 1'b1;
        end
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_bit_run_monitor.sv
`default_nettype none
// Testbench for bit_run_monitor: directed scenarios plus random runs against a run-length model.
module tb_bit_run_monitor;

  localparam int CNT_W       = 4;
  localparam int SYNC_STAGES = 2;
  localparam int MAXV        = (1 << CNT_W) - 1;

  logic             clk = 1'b0;
  logic             reset = 1'b0;
  logic             din = 1'b0;
  logic             en = 1'b0;
  logic             clr = 1'b0;
  logic             run_valid;
  logic [CNT_W-1:0] run_len;
  logic             run_level;
  logic             run_sat;
  logic [15:0]      run_cnt_total;
  logic             ovf_flag;

  bit_run_monitor #(.CNT_W(CNT_W), .SYNC_STAGES(SYNC_STAGES)) dut (
    .clk          (clk),
    .reset        (reset),
    .din          (din),
    .en           (en),
    .clr          (clr),
    .run_valid    (run_valid),
    .run_len      (run_len),
    .run_level    (run_level),
    .run_sat      (run_sat),
    .run_cnt_total(run_cnt_total),
    .ovf_flag     (ovf_flag)
  );

  always #10 clk = ~clk;

  int checks = 0;
  int errors = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Reference model: s is din as sampled SYNC_STAGES edges earlier; runs are plain integers.
  bit hist [SYNC_STAGES];
  bit m_sd;
  bit tracking;
  int run_n;
  bit m_valid;
  int m_len;
  bit m_level;
  bit m_sat;
  int m_total;
  bit m_ovf;

  always @(posedge clk or negedge reset) begin
    bit s_now;
    if (!reset) begin
      for (int i = 0; i < SYNC_STAGES; i++) hist[i] = 1'b0;
      m_sd = 0; tracking = 0; run_n = 0;
      m_valid = 0; m_len = 0; m_level = 0; m_sat = 0;
      m_total = 0; m_ovf = 0;
    end else begin
      s_now = hist[SYNC_STAGES-1];
      if (clr) begin
        m_total = 0;
        m_ovf   = 0;
      end else if (m_valid) begin
        m_total = (m_total + 1) % 65536;
        if (m_sat) m_ovf = 1;
      end
      m_valid = 0;
      if (en && (s_now != m_sd)) begin
        if (tracking) begin
          m_valid = 1;
          m_len   = (run_n > MAXV) ? MAXV : run_n;
          m_sat   = (run_n >= MAXV);
          m_level = m_sd;
        end
        tracking = 1;
        run_n    = 1;
      end else if (!en) begin
        tracking = 0;
      end else if (tracking) begin
        run_n++;
      end
      m_sd = s_now;
      for (int i = SYNC_STAGES - 1; i > 0; i--) hist[i] = hist[i-1];
      hist[0] = din;
    end
  end

  always @(negedge clk) begin
    if (reset) begin
      check("valid", run_valid, m_valid);
      check("len", run_len, m_len);
      check("sat", run_sat, m_sat);
      if (m_valid) check("level", run_level, m_level);
      check("total", run_cnt_total, m_total);
      check("ovf", ovf_flag, m_ovf);
    end
  end

  task automatic check_zero(input string tag);
    check({tag, "_valid"}, run_valid, 0);
    check({tag, "_len"}, run_len, 0);
    check({tag, "_level"}, run_level, 0);
    check({tag, "_sat"}, run_sat, 0);
    check({tag, "_total"}, run_cnt_total, 0);
    check({tag, "_ovf"}, ovf_flag, 0);
  endtask

  task automatic run_for(input int n);
    din = ~din;
    repeat (n) @(negedge clk);
  endtask

  initial begin
    reset = 1'b0; en = 1'b1; din = 1'b0; clr = 1'b0;
    repeat (6) begin
      @(negedge clk);
      din = ~din;
      check_zero("rst_hold");
    end
    #5 reset = 1'b1;
    @(negedge clk);

    // periodic 5-cycle runs
    for (int i = 0; i < 8; i++) run_for(5);

    // saturation, then a short run
    run_for(20);
    run_for(3);
    run_for(5);

    // single-cycle runs with a clear landing on a report
    for (int i = 0; i < 20; i++) begin
      clr = (i == 10);
      run_for(1);
    end
    clr = 1'b0;
    run_for(4);

    // enable dropped mid-run
    run_for(3);
    en = 1'b0;
    repeat (2) @(negedge clk);
    en = 1'b1;
    for (int i = 0; i < 4; i++) run_for(4);

    // asynchronous reset inside a run
    run_for(2);
    #2 reset = 1'b0;
    #1 check_zero("async_rst");
    #2 reset = 1'b1;
    @(negedge clk);
    repeat (3) @(negedge clk);
    for (int i = 0; i < 4; i++) run_for(5);

    // random runs with occasional enable drops and clears
    for (int r = 0; r < 300; r++) begin
      din = ~din;
      repeat ($urandom_range(1, 20)) begin
        en  = ($urandom_range(0, 29) != 0);
        clr = ($urandom_range(0, 39) == 0);
        @(negedge clk);
      end
    end
    en = 1'b1; clr = 1'b0;

    // enough single-cycle runs to wrap the 16-bit run total
    repeat (65540) run_for(1);
    repeat (10) @(negedge clk);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
